// File: rtl/me_best_mv_select_pkg.sv
// Shared types and defaults for the best-motion-vector selector.
package me_best_mv_select_pkg;

  localparam int SAD_W_DEF = 16;
  localparam int COL_W_DEF = 5;
  localparam int ROW_W_DEF = 7;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAD_W_DEF-1:0] cost;
    logic [COL_W_DEF-1:0] col;
    logic [ROW_W_DEF-1:0] row;
    logic                 hit;
  } entry_t;

  localparam entry_t ENTRY_CLR = '{cost: SAD_MAX, col: '0, row: '0, hit: 1'b0};

endpackage

// File: rtl/me_mv_cost.sv
// Candidate cost for one SAD sample. With ME_MV_PENALTY_EN defined the cost
// is SAD plus the L1 distance from the window center, saturated to all ones;
// otherwise the cost is the raw SAD and no arithmetic is built.
module me_mv_cost
  import me_best_mv_select_pkg::*;
#(
  parameter int SAD_W      = SAD_W_DEF,
  parameter int COL_W      = COL_W_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int CENTER_COL = 16,
  parameter int CENTER_ROW = 32
) (
  input  logic [SAD_W-1:0] sad_in,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [SAD_W-1:0] cost
);

`ifdef ME_MV_PENALTY_EN
  localparam int SUM_W = SAD_W + 2;
  localparam logic signed [COL_W+1:0] CCOL = (COL_W+2)'(CENTER_COL);
  localparam logic signed [ROW_W+1:0] CROW = (ROW_W+2)'(CENTER_ROW);

  function automatic logic [COL_W+1:0] abs_col(input logic signed [COL_W+1:0] d);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [ROW_W+1:0] abs_row(input logic signed [ROW_W+1:0] d);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [SAD_W-1:0] sat_cost(input logic [SUM_W-1:0] s);
    return (|s[SUM_W-1:SAD_W]) ? {SAD_W{1'b1}} : s[SAD_W-1:0];
  endfunction

  logic signed [COL_W+1:0] dcol;
  logic signed [ROW_W+1:0] drow;
  logic        [SUM_W-1:0] sum;

  // Distance to center on each axis, then saturating accumulate.
  always_comb begin
    dcol = $signed({2'b00, col}) - CCOL;
    drow = $signed({2'b00, row}) - CROW;
    sum  = SUM_W'(sad_in) + SUM_W'(abs_col(dcol)) + SUM_W'(abs_row(drow));
    cost = sat_cost(sum);
  end
`else
  logic unused_cfg;

  // Coordinates and center only matter for the penalised cost.
  assign unused_cfg = ^{col, row, CENTER_COL[0], CENTER_ROW[0]};
  assign cost       = sad_in;
`endif

endmodule

// File: rtl/me_best_mv_select.sv
// Tracks the minimum-cost candidate per coding sub-block across a search
// window sweep and emits the four best motion vectors over valid/ready.
// Optional macro ME_MV_PENALTY_EN adds a center-distance penalty to the cost.
module me_best_mv_select
  import me_best_mv_select_pkg::*;
#(
  parameter int SAD_W      = SAD_W_DEF,
  parameter int COL_W      = COL_W_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int CENTER_COL = 16,
  parameter int CENTER_ROW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [COL_W-1:0] search_column_count,
  input  logic [ROW_W-1:0] search_row_count,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [1:0]       mv_cb,
  output logic [COL_W-1:0] mv_col,
  output logic [ROW_W-1:0] mv_row,
  output logic [SAD_W-1:0] mv_sad,
  output logic             mv_hit,
  output logic             busy
);

  state_t           state;
  entry_t           trk     [4];
  entry_t           trk_nxt [4];
  logic [SAD_W-1:0] cost;
  logic             clr;
  logic             take;

  me_mv_cost #(
    .SAD_W      (SAD_W),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W),
    .CENTER_COL (CENTER_COL),
    .CENTER_ROW (CENTER_ROW)
  ) u_cost (
    .sad_in (sad_in),
    .col    (search_column_count),
    .row    (search_row_count),
    .cost   (cost)
  );

  // Next tracker contents: optional clear first, then the same-cycle sample.
  // frame_end in TRACK overrides a simultaneous frame_start, so no clear then.
  always_comb begin
    trk_nxt = trk;
    clr  = frame_start && ((state == IDLE) || ((state == TRACK) && !frame_end));
    take = sad_valid && ((state == TRACK) || ((state == IDLE) && frame_start));
    if (clr) begin
      for (int i = 0; i < 4; i++) trk_nxt[i] = ENTRY_CLR;
    end
    if (take) begin
      if (!trk_nxt[sad_cb].hit || (cost < trk_nxt[sad_cb].cost)) begin
        trk_nxt[sad_cb] = '{cost: cost, col: search_column_count,
                            row: search_row_count, hit: 1'b1};
      end
    end
  end

  // FSM, tracker storage and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int i = 0; i < 4; i++) trk[i] <= ENTRY_CLR;
      mv_valid <= 1'b0;
      mv_cb    <= 2'd0;
      mv_col   <= '0;
      mv_row   <= '0;
      mv_sad   <= '1;
      mv_hit   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trk <= trk_nxt;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= TRACK;
            busy  <= 1'b1;
          end
        end
        TRACK: begin
          if (frame_end) begin
            state    <= EMIT;
            mv_valid <= 1'b1;
            mv_cb    <= 2'd0;
            mv_col   <= trk_nxt[0].col;
            mv_row   <= trk_nxt[0].row;
            mv_sad   <= trk_nxt[0].cost;
            mv_hit   <= trk_nxt[0].hit;
          end
        end
        EMIT: begin
          if (mv_valid && mv_ready) begin
            if (mv_cb == 2'd3) begin
              state    <= IDLE;
              mv_valid <= 1'b0;
              busy     <= 1'b0;
            end else begin
              mv_cb  <= mv_cb + 2'd1;
              mv_col <= trk[mv_cb + 2'd1].col;
              mv_row <= trk[mv_cb + 2'd1].row;
              mv_sad <= trk[mv_cb + 2'd1].cost;
              mv_hit <= trk[mv_cb + 2'd1].hit;
            end
          end
        end
        default: begin
          state    <= IDLE;
          mv_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_me_best_mv_select.sv
// Scoreboard bench for me_best_mv_select: a small reference tracker predicts
// the four results at each frame_end and pushes them to a queue.
module tb_me_best_mv_select;

  localparam int SAD_W = 16;
  localparam int COL_W = 5;
  localparam int ROW_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start, frame_end, sad_valid, mv_ready;
  logic [1:0]       sad_cb;
  logic [SAD_W-1:0] sad_in;
  logic [COL_W-1:0] search_column_count;
  logic [ROW_W-1:0] search_row_count;
  logic             mv_valid, mv_hit, busy;
  logic [1:0]       mv_cb;
  logic [COL_W-1:0] mv_col;
  logic [ROW_W-1:0] mv_row;
  logic [SAD_W-1:0] mv_sad;

  always #5 clk = ~clk;

  me_best_mv_select dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_start         (frame_start),
    .frame_end           (frame_end),
    .sad_valid           (sad_valid),
    .sad_cb              (sad_cb),
    .sad_in              (sad_in),
    .search_column_count (search_column_count),
    .search_row_count    (search_row_count),
    .mv_valid            (mv_valid),
    .mv_ready            (mv_ready),
    .mv_cb               (mv_cb),
    .mv_col              (mv_col),
    .mv_row              (mv_row),
    .mv_sad              (mv_sad),
    .mv_hit              (mv_hit),
    .busy                (busy)
  );

  typedef struct packed {
    logic [1:0]       cb;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [SAD_W-1:0] sad;
    logic             hit;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [SAD_W-1:0] m_cost [4];
  logic [COL_W-1:0] m_col  [4];
  logic [ROW_W-1:0] m_row  [4];
  logic             m_hit  [4];
  logic             m_tracking = 1'b0;

  function automatic logic [SAD_W-1:0] m_costf(input logic [SAD_W-1:0] sad,
                                               input logic [COL_W-1:0] col,
                                               input logic [ROW_W-1:0] row);
`ifdef ME_MV_PENALTY_EN
    int s, dc, dr;
    logic [31:0] sv;
    dc = int'(col) - 16;
    dr = int'(row) - 32;
    if (dc < 0) dc = -dc;
    if (dr < 0) dr = -dr;
    s = int'(sad) + dc + dr;
    if (s > 65535) s = 65535;
    sv = s;
    return sv[SAD_W-1:0];
`else
    if (col == 0 && row == 0) return sad;
    return sad;
`endif
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_cost[i] = '1; m_col[i] = '0; m_row[i] = '0; m_hit[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; the reference tracker follows the same cycle's events.
  task automatic drive_cycle(input logic fs, input logic fe, input logic sv,
                             input logic [1:0] cb, input logic [SAD_W-1:0] sad,
                             input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    logic             was;
    logic [SAD_W-1:0] c;
    frame_start = fs; frame_end = fe; sad_valid = sv;
    sad_cb = cb; sad_in = sad; search_column_count = col; search_row_count = row;
    was = m_tracking;
    if (fs && !(was && fe)) m_clear();
    if (sv && (was || fs)) begin
      c = m_costf(sad, col, row);
      if (!m_hit[cb] || c < m_cost[cb]) begin
        m_cost[cb] = c; m_col[cb] = col; m_row[cb] = row; m_hit[cb] = 1'b1;
      end
    end
    if (fe && was) begin
      for (int i = 0; i < 4; i++) sb.push_back('{cb: 2'(i), col: m_col[i], row: m_row[i],
                                                 sad: m_cost[i], hit: m_hit[i]});
      m_tracking = 1'b0;
    end else if (fs) begin
      m_tracking = 1'b1;
    end
    tick();
    frame_start = 1'b0; frame_end = 1'b0; sad_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int c = 0;
    while (!mv_valid && c < limit) begin
      tick();
      c++;
    end
    if (!mv_valid) begin
      n_vec++; n_bad++;
      $display("FAIL %s: mv_valid=0 after %0d cycles, want 1", name, limit);
    end
  endtask

  // Accept n results with mv_ready high, checking each against the queue.
  task automatic drain(input string name, input int n, output int cyc);
    int   got = 0;
    exp_t e;
    cyc = 0;
    mv_ready = 1'b1;
    while (got < n && cyc < 40) begin
      if (mv_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL %s: unexpected result cb%0d, want none", name, mv_cb);
        end else begin
          e = sb.pop_front();
          if (exp_t'({mv_cb, mv_col, mv_row, mv_sad, mv_hit}) !== e) begin
            n_bad++;
            $display("FAIL %s: got cb=%0d col=%0d row=%0d sad=%0d hit=%0d, want cb=%0d col=%0d row=%0d sad=%0d hit=%0d",
                     name, mv_cb, mv_col, mv_row, mv_sad, mv_hit, e.cb, e.col, e.row, e.sad, e.hit);
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    mv_ready = 1'b0;
    if (got < n) begin
      n_vec++; n_bad++;
      $display("FAIL %s: only %0d of %0d results within budget", name, got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_vec++;
    if ({mv_valid, busy, mv_cb, mv_col, mv_row, mv_sad, mv_hit} !==
        {1'b0, 1'b0, 2'd0, 5'd0, 7'd0, 16'hFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got valid=%0d busy=%0d cb=%0d col=%0d row=%0d sad=%h hit=%0d, want 0 0 0 0 0 ffff 0",
               mv_valid, busy, mv_cb, mv_col, mv_row, mv_sad, mv_hit);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_min_tracking();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,   5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd0, 16'd500, 5'd3, 7'd10);
    drive_cycle(0, 0, 1, 2'd0, 16'd200, 5'd4, 7'd11);
    drive_cycle(0, 0, 1, 2'd0, 16'd200, 5'd5, 7'd12);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,   5'd0, 7'd0);
    n_vec++;
    if (mv_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mv_latency: mv_valid=%0d one cycle after frame_end, want 1", mv_valid);
    end
    drain("min_tracking", 4, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,      5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd2, 16'd90,     5'd1, 7'd1);
    drive_cycle(0, 0, 1, 2'd2, 16'd80,     5'd2, 7'd2);
    drive_cycle(0, 0, 1, 2'd2, 16'd85,     5'd3, 7'd3);
    drive_cycle(0, 0, 1, 2'd3, 16'hFFFF,   5'd1, 7'd2);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,      5'd0, 7'd0);
    drain("back_to_back", 4, cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,  5'd0,  7'd0);
    for (int i = 0; i < 4; i++)
      drive_cycle(0, 0, 1, 2'(i), 16'(40 + 3 * i), 5'(i + 6), 7'(i + 20));
    drive_cycle(0, 1, 0, 2'd0, 16'd0,  5'd0,  7'd0);
    mv_ready = 1'b0;
    wait_valid("bp_wait", 10);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (sb.size() == 0 ||
          {mv_valid, mv_cb, mv_col, mv_row, mv_sad, mv_hit} !== {1'b1, sb[0]}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%0d cb=%0d col=%0d row=%0d sad=%0d, want held cb0",
                 k, mv_valid, mv_cb, mv_col, mv_row, mv_sad);
      end
      tick();
    end
    drain("backpressure", 4, cyc);
    n_vec++;
    if (cyc !== 4 || busy !== 1'b0 || mv_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_burst: got cycles=%0d busy=%0d valid=%0d, want 4 0 0", cyc, busy, mv_valid);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,  5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd3, 16'd20, 5'd8, 7'd8);
    drive_cycle(0, 1, 1, 2'd3, 16'd7,  5'd9, 7'd9);
    drain("end_with_sample", 4, cyc);
    drive_cycle(1, 0, 0, 2'd0, 16'd0,   5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd0, 16'd10,  5'd1, 7'd1);
    drive_cycle(1, 0, 1, 2'd1, 16'd300, 5'd2, 7'd2);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,   5'd0, 7'd0);
    drain("restart_with_sample", 4, cyc);
  endtask

  task automatic test_reset_mid_emit();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,  5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd0, 16'd50, 5'd4, 7'd4);
    drive_cycle(0, 0, 1, 2'd1, 16'd60, 5'd5, 7'd5);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,  5'd0, 7'd0);
    drain("pre_reset_cb0", 1, cyc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    m_tracking = 1'b0;
    n_vec++;
    if (mv_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_emit: got valid=%0d busy=%0d, want 0 0", mv_valid, busy);
    end
    tick();
    drive_cycle(1, 0, 0, 2'd0, 16'd0,  5'd0, 7'd0);
    drive_cycle(0, 0, 1, 2'd1, 16'd70, 5'd7, 7'd7);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,  5'd0, 7'd0);
    drain("after_reset", 4, cyc);
  endtask

`ifdef ME_MV_PENALTY_EN
  task automatic test_penalty();
    int cyc;
    drive_cycle(1, 0, 0, 2'd0, 16'd0,    5'd0,  7'd0);
    drive_cycle(0, 0, 1, 2'd0, 16'd100,  5'd16, 7'd32);
    drive_cycle(0, 0, 1, 2'd0, 16'd95,   5'd26, 7'd32);
    drive_cycle(0, 0, 1, 2'd1, 16'hFFF0, 5'd0,  7'd0);
    drive_cycle(0, 1, 0, 2'd0, 16'd0,    5'd0,  7'd0);
    drain("penalty", 4, cyc);
  endtask
`endif

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; sad_valid = 1'b0; mv_ready = 1'b0;
    sad_cb = '0; sad_in = '0; search_column_count = '0; search_row_count = '0;
    m_clear();
    test_reset();
    test_min_tracking();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_emit();
`ifdef ME_MV_PENALTY_EN
    test_penalty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
